freq_meter: RTL

Measures the frequency of a slow clock or toggle signal, such as a `clock_gen` output, by counting its rising edges over a fixed window of system-clock cycles. It sits directly downstream of the clock generators and turns each generated clock into a number, which self-checking benches and status registers use to confirm the configured frequency. The measured input is asynchronous and is resynchronised internally. Single-shot and back-to-back continuous measurement are supported.

---
 rtl/freq_meter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// freq_meter: counts rising edges of an asynchronous input over a fixed
// window of GATE_CYCLES system clocks, single-shot or back-to-back.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   meas_in     - signal under measurement (asynchronous to clk)
//   start       - opens a window when sampled high in IDLE
//   continuous  - sampled at window end; high re-arms with no dead cycle
//   busy        - high while a window is open
//   done        - one-cycle pulse when count/overflow update
//   count       - rising edges seen in the last completed window
//   overflow    - last completed window saturated the counter
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned      WIN_W    = $clog2(GATE_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               meas_edge_c;
  logic               win_end_c;
  logic [CNT_W-1:0]   acc_nxt_c;
  logic               sat_nxt_c;

  assign meas_edge_c = s2_q & ~s3_q;
  assign win_end_c   = (state_q == GATE) && (win_q == '0);

  // State and datapath registers; synchroniser runs regardless of FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      win_q      <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= meas_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      win_q      <= win_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = GATE;
      GATE:    if (win_end_c && !continuous) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating accumulator step for the current cycle's edge
  always_comb begin
    acc_nxt_c = acc_q;
    sat_nxt_c = sat_q;
    if (meas_edge_c) begin
      if (acc_q == CNT_MAX) sat_nxt_c = 1'b1;
      else                  acc_nxt_c = acc_q + CNT_W'(1);
    end
  end

  // Output and counter logic; the last cycle's edge is folded into the result
  always_comb begin
    win_d      = win_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    done_d     = 1'b0;
    count_d    = count_q;
    overflow_d = overflow_q;
    busy_d     = (state_d == GATE);
    case (state_q)
      IDLE: begin
        if (start) begin
          win_d = WIN_LOAD;
          acc_d = '0;
          sat_d = 1'b0;
        end
      end
      GATE: begin
        if (win_end_c) begin
          count_d    = acc_nxt_c;
          overflow_d = sat_nxt_c;
          done_d     = 1'b1;
          // Reload unconditionally; a continuous re-arm starts from a clean slate
          win_d      = WIN_LOAD;
          acc_d      = '0;
          sat_d      = 1'b0;
        end else begin
          win_d = win_q - WIN_W'(1);
          acc_d = acc_nxt_c;
          sat_d = sat_nxt_c;
        end
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
